uart_tx_fifo: RTL

//  Byte buffer and launch controller sitting directly upstream of the UART transmitter.

---
 rtl/pkg_uart.sv | 17 +
 rtl/uart_sync_fifo.sv | 80 ++++++++
 rtl/uart_tx_fifo.sv | 106 ++++++++++
 3 files changed

// File: rtl/pkg_uart.sv
// Shared UART constants and the transmit feeder state type.
// TX_TIMEOUT allows two full frames (start + data + stop) before declaring the transmitter stuck.
package pkg_uart;

    localparam int DATA_WIDTH     = 8;
    localparam int CLOCKS_PER_BIT = 4;
    localparam int TX_FIFO_DEPTH  = 16;
    localparam int TX_TIMEOUT     = 2 * CLOCKS_PER_BIT * (DATA_WIDTH + 2);

    typedef enum bit [1:0] {
        F_IDLE      = 2'd0,
        F_LAUNCH    = 2'd1,
        F_WAIT_DONE = 2'd2,
        F_GAP       = 2'd3
    } tx_feed_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO with registered count/flags, sticky overflow and synchronous flush.
// Flags come straight from count_q so the write side never sees a path from the read side.
module uart_sync_fifo #(
    parameter int DEPTH      = pkg_uart::TX_FIFO_DEPTH,
    parameter int DATA_WIDTH = pkg_uart::DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_valid,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    wr_ready,
    input  logic                    flush,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty,
    output logic                    full,
    output logic                    overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  push, pop;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign wr_ready = !full;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign rd_data  = mem_q[rd_ptr_q];

    // Full blocks a write even when a pop frees a slot in the same cycle.
    assign push = wr_valid && !full && !flush;
    assign pop  = rd_en && !empty && !flush;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
            if (wr_valid && full)  overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffers system bytes and feeds them one at a time to the UART transmitter.
// A watchdog forces progress if the transmitter never reports TX_Done.
module uart_tx_fifo
    import pkg_uart::*;
#(
    parameter int DEPTH      = TX_FIFO_DEPTH,
    parameter int DATA_WIDTH = pkg_uart::DATA_WIDTH,
    parameter int TIMEOUT    = TX_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_valid,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    wr_ready,
    input  logic                    flush,
    output logic                    TX_Data_Valid,
    output logic [DATA_WIDTH-1:0]   TX_Byte,
    input  logic                    TX_Active,
    input  logic                    TX_Done,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty,
    output logic                    full,
    output logic                    overflow,
    output logic                    tx_timeout
);

    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    tx_feed_state_e        state_q, state_d;
    logic [WDW-1:0]        wd_q, wd_d;
    logic [DATA_WIDTH-1:0] tx_byte_q, tx_byte_d;
    logic                  tx_dv_q, tx_dv_d;
    logic                  tx_timeout_q, tx_timeout_d;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_en;
    logic                  launch;
    logic                  wd_expire;

    uart_sync_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .flush    (flush),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow)
    );

    // A flush landing between detect and launch leaves nothing to send; skip the strobe.
    assign launch    = (state_q == F_LAUNCH) && !empty;
    assign wd_expire = (state_q == F_WAIT_DONE) && !TX_Done && (wd_q == WD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= F_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            F_IDLE:      if (!empty && !TX_Active) state_d = F_LAUNCH;
            F_LAUNCH:    state_d = launch ? F_WAIT_DONE : F_IDLE;
            F_WAIT_DONE: if (TX_Done || wd_q == WD_LAST) state_d = F_GAP;
            F_GAP:       state_d = F_IDLE;
            default:     state_d = F_IDLE;
        endcase
    end

    always_comb begin
        rd_en        = launch;
        tx_dv_d      = launch;
        tx_byte_d    = launch ? rd_data : tx_byte_q;
        tx_timeout_d = tx_timeout_q | wd_expire;
        wd_d         = wd_q;
        if (state_q == F_LAUNCH)         wd_d = '0;
        else if (state_q == F_WAIT_DONE) wd_d = wd_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q         <= '0;
            tx_byte_q    <= '0;
            tx_dv_q      <= 1'b0;
            tx_timeout_q <= 1'b0;
        end else begin
            wd_q         <= wd_d;
            tx_byte_q    <= tx_byte_d;
            tx_dv_q      <= tx_dv_d;
            tx_timeout_q <= tx_timeout_d;
        end
    end

    assign TX_Data_Valid = tx_dv_q;
    assign TX_Byte       = tx_byte_q;
    assign tx_timeout    = tx_timeout_q;

endmodule
